// File: rtl/music_pkg.sv
// Shared types and default widths for the music streamer.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int DEF_ADDR_WIDTH = 18;
   localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/sample_fifo.sv
// Small show-ahead synchronous FIFO holding prefetched audio samples.
module sample_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         head,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_q;
   logic [AW-1:0]         rd_q;
   logic [AW:0]           cnt_q;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !flush && !empty;
   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign do_push = push && !flush && ((cnt_q != (AW+1)'(FIFO_DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/music_streamer.sv
// Streams a clip of samples from a pipelined ROM through a prefetch FIFO,
// releasing one sample per sample_tick, with optional looping.
module music_streamer
   import music_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ROM_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop_en,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   input  logic                  sample_tick,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] sample_out,
   output logic                  sample_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CW    = CNT_W + 1;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [ADDR_WIDTH-1:0]  end_q, end_d;
   logic [ROM_LATENCY-1:0] vld_q, vld_d, vld_shift;
   logic [DATA_WIDTH-1:0]  sample_q, sample_d;
   logic                   sample_valid_q, underrun_q;
   logic                   abort;

   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_empty;
   logic [DATA_WIDTH-1:0]  fifo_head;
   logic [CW-1:0]          inflight_cnt;
   logic                   issue, push, pop;

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
         inflight_cnt = inflight_cnt + CW'(vld_q[i]);
      end
   end

   // Reads are only issued when the FIFO is guaranteed room for the returning data.
   assign issue = (state_q == ST_FETCH) &&
                  ((CW'(fifo_count) + inflight_cnt) < CW'(FIFO_DEPTH));
   assign push  = vld_q[ROM_LATENCY-1];
   assign abort = stop && (state_q != ST_IDLE);
   assign pop   = sample_tick && !abort && (state_q != ST_IDLE) && !fifo_empty;

   generate
      if (ROM_LATENCY == 1) begin : g_lat1
         assign vld_shift = issue;
      end else begin : g_latn
         assign vld_shift = {vld_q[ROM_LATENCY-2:0], issue};
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      base_d   = base_q;
      end_d    = end_q;
      done     = 1'b0;
      vld_d    = abort ? '0 : vld_shift;
      sample_d = pop ? fifo_head : sample_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop && (inflight_cnt == '0)) begin
               base_d  = base_addr;
               end_d   = (end_addr < base_addr) ? base_addr : end_addr;
               ptr_d   = base_addr;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               if (ptr_q == end_q) begin
                  if (loop_en) ptr_d = base_q;
                  else         state_d = ST_DRAIN;
               end else begin
                  ptr_d = ptr_q + ADDR_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && (inflight_cnt == '0)) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d = ST_IDLE;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ptr_q          <= '0;
         base_q         <= '0;
         end_q          <= '0;
         vld_q          <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         base_q         <= base_d;
         end_q          <= end_d;
         vld_q          <= vld_d;
         sample_q       <= sample_d;
         sample_valid_q <= pop;
         underrun_q     <= sample_tick && !abort && (state_q == ST_FETCH) && fifo_empty;
      end
   end

   sample_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (abort),
      .push      (push),
      .push_data (rom_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign rom_en       = issue;
   assign rom_addr     = ptr_q;
   assign sample_out   = sample_q;
   assign sample_valid = sample_valid_q;
   assign underrun     = underrun_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/music_streamer.md
MUSIC_STREAMER -- requirements
Module: music_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, default 18, ROM address width.
REQ-002 Parameter DATA_WIDTH, default 8, sample width.
REQ-003 Parameter ROM_LATENCY, default 1, legal 1..3, cycles from rom_en to valid rom_data.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two >= ROM_LATENCY+1, prefetch depth.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begin playback.
REQ-008 stop  in  1  one-cycle pulse; abort playback.
REQ-009 loop_en  in  1  wrap from end_addr to base_addr instead of finishing.
REQ-010 base_addr  in  ADDR_WIDTH  first sample address; sampled on accepted start.
REQ-011 end_addr  in  ADDR_WIDTH  last sample address, inclusive; sampled on accepted start.
REQ-012 sample_tick  in  1  one-cycle strobe at audio sample rate.
REQ-013 rom_en  out  1  ROM read enable.
REQ-014 rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-015 rom_data  in  DATA_WIDTH  ROM read data, valid ROM_LATENCY cycles after rom_en.
REQ-016 sample_out  out  DATA_WIDTH  current audio sample, registered.
REQ-017 sample_valid  out  1  one-cycle pulse when sample_out is updated.
REQ-018 busy  out  1  high in FETCH or DRAIN.
REQ-019 done  out  1  one-cycle pulse on natural end of playback.
REQ-020 underrun  out  1  one-cycle pulse on sample_tick with empty FIFO while in FETCH.

Function
REQ-021 States: IDLE, FETCH, DRAIN.
REQ-022 IDLE: start with no read in flight latches base/end, sets fetch pointer = base_addr, moves to FETCH; start with reads in flight is ignored.
REQ-023 FETCH: rom_en = 1 whenever FIFO occupancy + in-flight reads < FIFO_DEPTH; rom_addr = fetch pointer; pointer increments after each issue.
REQ-024 Issue at pointer == end: loop_en = 1 -> pointer = base; loop_en = 0 -> no further issues, go DRAIN.
REQ-025 base > end is treated as base == end (single-sample clip).
REQ-026 Returned rom_data is pushed into the FIFO exactly ROM_LATENCY cycles after its rom_en; no push is ever dropped, because the credit rule guarantees space.
REQ-027 sample_tick in FETCH/DRAIN with FIFO non-empty: pop head to sample_out and pulse sample_valid on the next cycle.
REQ-028 Same-cycle push and pop both take effect; occupancy is unchanged.
REQ-029 sample_tick in FETCH with FIFO empty: underrun pulses and sample_out holds its value.
REQ-030 DRAIN with FIFO empty and zero in flight: done pulses and the state returns to IDLE in the same cycle.
REQ-031 stop in FETCH/DRAIN: go to IDLE next cycle and flush the FIFO; rom_data returns for outstanding reads are discarded; sample_out holds.
REQ-032 stop and start in the same cycle: stop wins; start is ignored.
REQ-033 sample_tick in IDLE is ignored; no sample_valid and no underrun.
REQ-034 The fetch pointer wraps modulo 2^ADDR_WIDTH if end is the maximum address.

Reset
REQ-035 rst_n low: state = IDLE; FIFO empty; in-flight count 0; rom_en, sample_valid, done, underrun, busy = 0; rom_addr = 0; sample_out = 0.
REQ-036 Reset mid-playback aborts immediately; ROM data returning after reset release is discarded.

Structure
REQ-037 Shared package music_pkg holds the state enum and default ADDR_WIDTH/DATA_WIDTH constants.
REQ-038 Sub-module sample_fifo: synchronous FIFO with DATA_WIDTH/FIFO_DEPTH parameters and count output.
REQ-039 The in-flight tracker is a ROM_LATENCY-deep valid shift register inside music_streamer.

Verification
REQ-040 ROM holds data = addr[7:0], ROM_LATENCY = 1; start with base = 0x10, end = 0x13, loop_en = 0, tick every 8 cycles -> sample_out 0x10, 0x11, 0x12, 0x13; one done pulse; busy then falls.
REQ-041 Same setup with loop_en = 1 and 10 ticks -> 0x10..0x13, 0x10..0x13, 0x10, 0x11; no done.
REQ-042 ROM_LATENCY = 3, tick on every cycle -> underrun pulses while the FIFO refills; no sample is skipped or duplicated in the output order.
REQ-043 stop after the second sample, then start at base = 0x40, end = 0x41 -> next samples are 0x40, 0x41 only; no stale 0x12.
REQ-044 rst_n asserted mid-FETCH, then start at base = 0x00, end = 0x00 -> all outputs 0 during reset; afterwards a single sample 0x00 then done.
REQ-045 start and stop in the same cycle in IDLE -> busy stays 0; no rom_en is issued.
